// File: rtl/instr_issuer.sv
// Instruction issuer: loader FIFO feeding a hold-timed issue FSM.
// Drives cpu.instruction; NOP (zero) whenever nothing is being held.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   wr_en, wr_instr    loader write into the FIFO
//   run                issue enable (level)
//   full, empty, level FIFO status; overflow is sticky on dropped writes
//   instruction        bus to the cpu
//   issue_valid        pulse on the first cycle of each instruction
//   busy               high while an instruction is held
module instr_issuer #(
  parameter int WIDTH_DATA = 16,
  parameter int FAWIDTH    = 3,
  parameter int HOLD_SHORT = 4,
  parameter int HOLD_LONG  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH_DATA-1:0] wr_instr,
  input  logic                  run,
  output logic                  full,
  output logic                  empty,
  output logic [FAWIDTH:0]      level,
  output logic                  overflow,
  output logic [WIDTH_DATA-1:0] instruction,
  output logic                  issue_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << FAWIDTH;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];

  logic [FAWIDTH:0]      wr_ptr_q, wr_ptr_d;
  logic [FAWIDTH:0]      rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  state_t                state_q, state_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [WIDTH_DATA-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  wr_ok;
  logic                  pop;
  logic                  free_slot;
  logic [WIDTH_DATA-1:0] head;

  // Opcode to total on-bus cycles; opcode 0 still occupies one slot.
  function automatic logic [7:0] hold_of(input logic [4:0] op);
    logic [7:0] h;
    unique case (1'b1)
      (op == 5'd0):                 h = 8'd1;
      (op == 5'd4 || op == 5'd21):  h = 8'(HOLD_LONG);
      default:                      h = 8'(HOLD_SHORT);
    endcase
    return h;
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (FAWIDTH+1)'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem_q[rd_ptr_q[FAWIDTH-1:0]];

  assign wr_ok = wr_en && !full;

  // A new instruction may start when idle or on the last hold cycle.
  assign free_slot = (state_q == IDLE) || (hold_cnt_q == 8'd0);
  assign pop       = run && !empty && free_slot;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_ok)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_en && full)
      overflow_d = 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    if (pop) begin
      state_d    = ISSUE;
      instr_d    = head;
      valid_d    = 1'b1;
      hold_cnt_d = hold_of(head[WIDTH_DATA-1 -: 5]) - 8'd1;
    end else begin
      unique case (state_q)
        IDLE: begin
          instr_d = '0;
        end
        ISSUE: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end else begin
            state_d = IDLE;
            instr_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          instr_d = '0;
        end
      endcase
    end
    busy_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wr_ptr_q[FAWIDTH-1:0]] <= wr_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign overflow    = overflow_q;
  assign instruction = instr_q;
  assign issue_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_instr;
  logic        run;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] instruction;
  logic        issue_valid;
  logic        busy;

  always #5 clk = ~clk;

  instr_issuer dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_instr(wr_instr),
    .run(run),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .instruction(instruction),
    .issue_valid(issue_valid),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int pulses   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: queue of pending words, the word on the bus and
  // how many bus cycles it still has (0 means bus shows NOP).
  logic [15:0] mq[$];
  logic [15:0] m_cur   = '0;
  int          m_left  = 0;
  bit          m_valid = 0;
  bit          m_ovf   = 0;

  function automatic int hold_len(input logic [15:0] w);
    case (w[15:11])
      5'd0:        return 1;
      5'd4, 5'd21: return 8;
      default:     return 4;
    endcase
  endfunction

  task automatic model_edge();
    int  sz;
    bit  can_pop;
    if (reset) begin
      mq.delete();
      m_cur   = '0;
      m_left  = 0;
      m_valid = 0;
      m_ovf   = 0;
    end else begin
      sz      = mq.size();
      can_pop = run && sz > 0 && m_left <= 1;
      m_valid = 0;
      if (can_pop) begin
        m_cur   = mq.pop_front();
        m_left  = hold_len(m_cur);
        m_valid = 1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_cur = '0;
      end
      if (wr_en) begin
        if (sz == 8) m_ovf = 1;
        else mq.push_back(wr_instr);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (issue_valid) pulses++;
    chk("instr", instruction, (m_left > 0) ? m_cur : 16'h0);
    chk("valid", issue_valid, m_valid);
    chk("busy", busy, m_left > 0);
    chk("level", level, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 8);
    chk("ovf", overflow, m_ovf);
  endtask

  task automatic wr(input logic [15:0] w);
    wr_en    = 1'b1;
    wr_instr = w;
    step();
    wr_en    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [4:0] op;
    case ($urandom_range(0, 6))
      0: op = 5'd0;
      1: op = 5'd1;
      2: op = 5'd4;
      3: op = 5'd20;
      4: op = 5'd21;
      default: op = 5'($urandom);
    endcase
    return {op, 11'($urandom)};
  endfunction

  initial begin
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_instr = '0;
    run      = 1'b0;

    do_reset();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_instr", instruction, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);

    // CALL sequence: 4 + 4 + 8 back-to-back
    wr(16'hA005);
    wr(16'hA004);
    wr(16'hA800);
    pulses = 0;
    run = 1'b1;
    repeat (20) step();
    chk("call_pulses", pulses, 3);
    chk("call_idle", busy, 0);

    // Stack arithmetic
    run = 1'b0;
    wr(16'h0805);
    wr(16'h0802);
    wr(16'h2000);
    pulses = 0;
    run = 1'b1;
    repeat (20) step();
    chk("stack_pulses", pulses, 3);

    // Overflow: nine writes into an eight-deep FIFO
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr({5'd1, 11'(i)});
      if (i == 7) chk("ovf_full8", full, 1);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 8);
    pulses = 0;
    run = 1'b1;
    repeat (40) step();
    chk("ovf_pulses", pulses, 8);
    chk("ovf_sticky", overflow, 1);

    // run gating: drop run in 2nd cycle of ADD
    do_reset();
    run = 1'b0;
    wr(16'h2000);
    wr(16'h0805);
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    repeat (10) step();
    chk("gate_level", level, 1);
    chk("gate_instr", instruction, 0);
    run = 1'b1;
    step();
    chk("gate_push", instruction, 16'h0805);
    repeat (6) step();

    // Reset in cycle 3 of a RET hold
    run = 1'b0;
    wr(16'hA800);
    wr(16'h0805);
    wr(16'h0805);
    run = 1'b1;
    repeat (3) step();
    chk("ret_busy", busy, 1);
    do_reset();
    chk("rmid_instr", instruction, 0);
    chk("rmid_level", level, 0);
    pulses = 0;
    repeat (10) step();
    chk("rmid_pulses", pulses, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_instr = rnd_word();
      run      = ($urandom_range(0, 7) != 0);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Instruction-side driver for `cpu`; it is the producer end of the 16-bit `instruction` bus.
- A loader, either a bench or a boot ROM walker, writes encoded instructions {opcode[15:11], operand[10:0]} into an internal FIFO.
- The issuer pops each instruction and holds it stable on `instruction` for an opcode-dependent number of cycles, so the multi-cycle CPU sequencing completes.
- Between instructions and when idle, it drives NOP (16'h0000).

Parameters:
- WIDTH_DATA, 16, instruction width; opcode is bits [WIDTH_DATA-1 -: 5], operand is the remaining bits.
- FAWIDTH, 3, FIFO address width; depth = 2**FAWIDTH entries.
- HOLD_SHORT, 4, cycles to hold PUSH_I (1), CALL (20) and every other non-NOP opcode.
- HOLD_LONG, 8, cycles to hold ADD (4) and RET (21).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  loader write strobe.
- wr_instr  in  WIDTH_DATA  instruction to enqueue.
- run  in  1  level input; issue only while high.
- full  out  1  FIFO holds 2**FAWIDTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  FAWIDTH+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a write is attempted while full.
- instruction  out  WIDTH_DATA  to cpu.instruction.
- issue_valid  out  1  one-cycle pulse on the first cycle a new instruction is driven.
- busy  out  1  high while in ISSUE state.

Behaviour:
- Reset: FIFO pointers and level = 0, empty=1, full=0, overflow=0, instruction=16'h0000, issue_valid=0, busy=0, state=IDLE. Reset mid-ISSUE aborts the instruction and discards FIFO contents.
- FIFO: circular buffer; pointers are FAWIDTH+1 bits and wrap naturally.
  - Write while full: dropped, overflow<=1.
  - Write while not full: stored, level+1 unless a pop occurs in the same cycle.
  - Simultaneous write and pop: allowed when not full. Level unchanged. When empty, a write is not visible for popping until the next cycle (no fall-through).
- FSM states: IDLE, ISSUE.
  - IDLE: instruction=0, busy=0. If run && !empty: pop head; next cycle instruction=head, issue_valid=1, busy=1, hold_cnt=HOLD(opcode)-1, go ISSUE.
  - ISSUE: instruction held constant; issue_valid=0 after the first cycle. When hold_cnt>0: decrement.
  - ISSUE with hold_cnt==0 (last hold cycle), if run && !empty: pop, and the next instruction is driven in the following cycle with issue_valid pulse (back-to-back, no NOP gap).
  - ISSUE with hold_cnt==0, otherwise: go IDLE; instruction=0 the following cycle.
- run deasserted during ISSUE: the current instruction completes its full hold; then IDLE.
- Opcode 0 in the FIFO: issued as a 1-cycle hold, counted as an instruction.
- Latency: first drive occurs 1 cycle after the pop cycle; total on-bus time per instruction is exactly HOLD(opcode) cycles.
- issue_valid is never high in two consecutive cycles unless a hold of 1 occurs.

Test Plan:
- Reset: after reset, assert level=0, empty=1, instruction=0, busy=0, overflow=0.
- CALL sequence: write 16'hA005, 16'hA004, 16'hA800, then run=1. Expect the following, with 3 issue_valid pulses in total:
  - A005 held 4 cycles, then A004 held 4 cycles, then A800 held 8 cycles, all back-to-back.
  - Then instruction=0 and busy=0.
- Stack arithmetic: write 16'h0805, 16'h0802, 16'h2000. Expect holds of 4, 4 and 8 cycles; level decrements 3→2→1→0 on each pop cycle.
- Overflow: with run=0, write 9 words. Expect full=1 after the 8th write, overflow=1 after the 9th, level=8. Then run=1: exactly 8 instructions are issued, the 9th is absent, and overflow stays 1 until reset.
- run gating: drop run during the 2nd cycle of an ADD (16'h2000) with a queued PUSH_I. Expect ADD held the full 8 cycles, then instruction=0 and level=1. Re-raise run: PUSH_I issues on the next cycle plus 1.
- Reset mid-op: assert reset in cycle 3 of a RET hold with 2 entries queued. Expect the reset values on the next edge, and no further issues after run stays high.
